ahb_sram_slave: RTL and testbench

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

---
 rtl/ahb_sram_if.sv | 23 ++
 rtl/ahb_sram_slave.sv | 117 +++++++++++
 tb/tb_ahb_sram_slave.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_if.sv
// rtl/ahb_sram_if.sv - AHB-Lite bus bundle between a master/decoder and the SRAM slave
interface ahb_sram_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hreadyin;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic [1:0]  hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hreadyin,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hreadyin,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite SRAM slave with two-cycle ERROR; AHB_SLV_WAIT_EN adds wait states
module ahb_sram_slave #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       hclk,
    input  logic       hreset_n,
    ahb_sram_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    if (DEPTH < 4 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0 ||
        WAIT_CYCLES < 0 || WAIT_CYCLES > 7) begin : g_param_check
        $error("ahb_sram_slave: DEPTH or WAIT_CYCLES out of range");
    end

    logic [31:0]   mem [DEPTH];
    logic [2:0]    state;
    logic [AW-1:0] idx;
    logic          wr;
    logic [2:0]    size;
    logic [1:0]    lsb;
    logic          can_accept;
    logic          accept;
    logic          bad;
    logic [3:0]    be;
`ifdef AHB_SLV_WAIT_EN
    logic [2:0]    wait_cnt;
`endif

    // Only states that drive hreadyout=1 can overlap a new address phase.
    assign can_accept = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
    assign accept     = can_accept && bus.hsel && bus.hreadyin && bus.htrans[1];

    assign bad = (|bus.haddr[31:AW+2]) ||
                 (bus.hsize > 3'b010) ||
                 ((bus.hsize == 3'b001) && bus.haddr[0]) ||
                 ((bus.hsize == 3'b010) && (bus.haddr[1:0] != 2'b00));

    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            wr       <= 1'b0;
            size     <= 3'b000;
            lsb      <= 2'b00;
`ifdef AHB_SLV_WAIT_EN
            wait_cnt <= 3'd0;
`endif
        end else if (accept) begin
            idx  <= bus.haddr[AW+1:2];
            wr   <= bus.hwrite;
            size <= bus.hsize;
            lsb  <= bus.haddr[1:0];
            if (bad) begin
                state <= ST_ERR1;
            end else begin
`ifdef AHB_SLV_WAIT_EN
                if (WAIT_CYCLES == 0) begin
                    state <= ST_DATA;
                end else begin
                    state    <= ST_WAIT;
                    wait_cnt <= 3'(WAIT_CYCLES - 1);
                end
`else
                state <= ST_DATA;
`endif
            end
        end else begin
            case (state)
`ifdef AHB_SLV_WAIT_EN
                ST_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state <= ST_DATA;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
`endif
                ST_ERR1: state <= ST_ERR2;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Little-endian lane enables from the captured size and low address bits.
    always_comb begin
        be = 4'b0000;
        case (size)
            3'b000:  be[lsb] = 1'b1;
            3'b001:  be = lsb[1] ? 4'b1100 : 4'b0011;
            3'b010:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // A reset on the commit edge abandons the write.
    always_ff @(posedge hclk) begin
        if (hreset_n && (state == ST_DATA) && wr) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem[idx][8*k +: 8] <= bus.hwdata[8*k +: 8];
                end
            end
        end
    end

    assign bus.hreadyout = !((state == ST_WAIT) || (state == ST_ERR1));
    assign bus.hresp     = ((state == ST_ERR1) || (state == ST_ERR2)) ? 2'b01 : 2'b00;
    assign bus.hrdata    = ((state == ST_DATA) && !wr) ? mem[idx] : 32'h0;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - bench for ahb_sram_slave: vector table, reset-abort sequence, random traffic vs byte model
module tb_ahb_sram_slave;
    localparam int DEPTH       = 64;
    localparam int WAIT_CYCLES = 2;
    localparam int AW          = 6;
`ifdef AHB_SLV_WAIT_EN
    localparam int W = WAIT_CYCLES;
`else
    localparam int W = 0;
`endif

    logic hclk     = 1'b0;
    logic hreset_n = 1'b0;
    always #5 hclk = ~hclk;

    ahb_sram_if bus ();
    assign bus.hreadyin = bus.hreadyout;

    ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .bus      (bus)
    );

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        has_exp;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } xfer_t;

    xfer_t      q[$];
    xfer_t      tbl[22];
    logic [7:0] mb [DEPTH*4];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic xfer_t mk(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                                 input logic wr, input logic [2:0] size, input logic [31:0] wdata,
                                 input logic has_exp, input logic exp_err, input logic [31:0] exp_rdata);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.addr = addr; x.wr = wr; x.size = size; x.wdata = wdata;
        x.has_exp = has_exp; x.exp_err = exp_err; x.exp_rdata = exp_rdata;
        return x;
    endfunction

    function automatic logic is_err(input xfer_t x);
        return ((x.addr >> (AW + 2)) != 0) || (x.size > 3'd2) ||
               ((x.size == 3'd1) && x.addr[0]) ||
               ((x.size == 3'd2) && (x.addr[1:0] != 2'b00));
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int base;
        base = int'(a[AW+1:0]) & ~3;
        return {mb[base+3], mb[base+2], mb[base+1], mb[base]};
    endfunction

    task automatic model_write(input xfer_t x);
        int n, first, b;
        n     = 1 << x.size;
        first = int'(x.addr[AW+1:0]) & ~(n - 1);
        for (int i = 0; i < n; i++) begin
            b = first + i;
            mb[b] = x.wdata[8*(b%4) +: 8];
        end
    endtask

    task automatic present(output xfer_t a, output int a_kind);
        if (q.size() > 0) begin
            a = q.pop_front();
            a_kind = (a.sel && a.trans[1]) ? 2 : 1;
        end else begin
            a = mk(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0);
            a_kind = 0;
        end
        bus.hsel   = a.sel;
        bus.htrans = a.trans;
        bus.haddr  = a.addr;
        bus.hwrite = a.wr;
        bus.hsize  = a.size;
    endtask

    // Pipelined master: next address is driven while the previous data phase runs.
    task automatic run_queue();
        xfer_t a, d;
        int    a_kind, d_kind, low;
        logic  ready, last_ready, d_err;
        logic [31:0] exp_rd;
        d_kind = 0; low = 0; d_err = 1'b0; last_ready = 1'b1;
        d = mk(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(posedge hclk); #1;
        present(a, a_kind);
        forever begin
            @(negedge hclk);
            ready = bus.hreadyout;
            if (d_kind == 1) begin
                chk("idle_ready", {31'h0, ready}, 32'h1);
                chk("idle_resp", {30'h0, bus.hresp}, 32'h0);
                chk("idle_rdata", bus.hrdata, 32'h0);
                d_kind = 0;
            end else if (d_kind == 2) begin
                if (!ready) begin
                    low++;
                    chk("wait_resp", {30'h0, bus.hresp}, d_err ? 32'h1 : 32'h0);
                    chk("wait_rdata", bus.hrdata, 32'h0);
                    if (low > 20) begin
                        errors++;
                        $display("FAIL timeout: hreadyout low %0d cycles, required at most %0d", low, 20);
                        $fatal(1, "slave stuck with hreadyout low");
                    end
                end else begin
                    chk("wait_len", low, d_err ? 32'd1 : W);
                    chk("resp", {30'h0, bus.hresp}, d_err ? 32'h1 : 32'h0);
                    if (d.wr || d_err) exp_rd = 32'h0;
                    else if (d.has_exp) exp_rd = d.exp_rdata;
                    else exp_rd = model_read(d.addr);
                    chk("rdata", bus.hrdata, exp_rd);
                    if (d.wr && !d_err) model_write(d);
                    d_kind = 0;
                end
            end
            last_ready = ready;
            if (d_kind == 0 && a_kind == 0 && q.size() == 0 && ready) break;
            @(posedge hclk); #1;
            if (last_ready) begin
                d = a; d_kind = a_kind; low = 0;
                if (d_kind == 2) begin
                    bus.hwdata = d.wdata;
                    d_err = d.has_exp ? d.exp_err : is_err(d);
                end
                present(a, a_kind);
            end
        end
    endtask

    initial begin
        xfer_t r, dummy;
        int    dk;
        bus.hsel = 1'b0; bus.htrans = 2'b00; bus.haddr = 32'h0; bus.hwrite = 1'b0;
        bus.hsize = 3'd0; bus.hwdata = 32'h0;
        hreset_n = 1'b0;
        repeat (3) @(posedge hclk);
        #1 hreset_n = 1'b1;
        @(negedge hclk);
        chk("rst_ready", {31'h0, bus.hreadyout}, 32'h1);
        chk("rst_resp", {30'h0, bus.hresp}, 32'h0);
        chk("rst_rdata", bus.hrdata, 32'h0);

        tbl[0]  = mk(1, 2'b10, 32'h10,  1, 3'd2, 32'hDEADBEEF, 1, 0, 32'h0);
        tbl[1]  = mk(1, 2'b10, 32'h10,  0, 3'd2, 32'h0,        1, 0, 32'hDEADBEEF);
        tbl[2]  = mk(1, 2'b10, 32'h20,  1, 3'd2, 32'h0,        1, 0, 32'h0);
        tbl[3]  = mk(1, 2'b10, 32'h21,  1, 3'd0, 32'h00001100, 1, 0, 32'h0);
        tbl[4]  = mk(1, 2'b10, 32'h23,  1, 3'd0, 32'h22000000, 1, 0, 32'h0);
        tbl[5]  = mk(1, 2'b10, 32'h20,  0, 3'd2, 32'h0,        1, 0, 32'h22001100);
        tbl[6]  = mk(1, 2'b10, 32'h00,  1, 3'd2, 32'h01234567, 1, 0, 32'h0);
        tbl[7]  = mk(1, 2'b10, 32'h02,  0, 3'd2, 32'h0,        1, 1, 32'h0);
        tbl[8]  = mk(1, 2'b10, 32'h02,  1, 3'd2, 32'hFFFFFFFF, 1, 1, 32'h0);
        tbl[9]  = mk(1, 2'b10, 32'h00,  0, 3'd2, 32'h0,        1, 0, 32'h01234567);
        tbl[10] = mk(1, 2'b10, 32'h100, 1, 3'd2, 32'hCAFEF00D, 1, 1, 32'h0);
        tbl[11] = mk(1, 2'b10, 32'h04,  1, 3'd2, 32'h5,        1, 0, 32'h0);
        tbl[12] = mk(1, 2'b10, 32'h04,  0, 3'd2, 32'h0,        1, 0, 32'h5);
        tbl[13] = mk(1, 2'b10, 32'h12,  1, 3'd1, 32'hBEEF0000, 1, 0, 32'h0);
        tbl[14] = mk(1, 2'b10, 32'h10,  0, 3'd2, 32'h0,        1, 0, 32'hBEEFBEEF);
        tbl[15] = mk(1, 2'b10, 32'h11,  0, 3'd1, 32'h0,        1, 1, 32'h0);
        tbl[16] = mk(1, 2'b10, 32'h00,  0, 3'd3, 32'h0,        1, 1, 32'h0);
        tbl[17] = mk(0, 2'b10, 32'h04,  1, 3'd2, 32'hFFFFFFFF, 1, 0, 32'h0);
        tbl[18] = mk(1, 2'b01, 32'h04,  1, 3'd2, 32'hFFFFFFFF, 1, 0, 32'h0);
        tbl[19] = mk(1, 2'b11, 32'h04,  0, 3'd2, 32'h0,        1, 0, 32'h5);
        tbl[20] = mk(1, 2'b10, 32'h13,  0, 3'd0, 32'h0,        1, 0, 32'hBEEFBEEF);
        tbl[21] = mk(1, 2'b10, 32'h08,  1, 3'd2, 32'h0,        1, 0, 32'h0);
        for (int i = 0; i < 22; i++) q.push_back(tbl[i]);
        run_queue();

        // Reset lands on the cycle after a write is accepted: the write must vanish.
        @(posedge hclk); #1;
        q.push_back(mk(1, 2'b10, 32'h08, 1, 3'd2, 32'hA5A5A5A5, 1, 0, 32'h0));
        present(dummy, dk);
        @(posedge hclk); #1;
        present(dummy, dk);
        bus.hwdata = 32'hA5A5A5A5;
        hreset_n = 1'b0;
        @(posedge hclk); #1;
        hreset_n = 1'b1;
        @(negedge hclk);
        chk("abort_ready", {31'h0, bus.hreadyout}, 32'h1);
        chk("abort_resp", {30'h0, bus.hresp}, 32'h0);
        chk("abort_rdata", bus.hrdata, 32'h0);
        q.push_back(mk(1, 2'b10, 32'h08, 0, 3'd2, 32'h0, 1, 0, 32'h0));
        run_queue();

        for (int w = 0; w < DEPTH; w++)
            q.push_back(mk(1, 2'b10, 32'(w * 4), 1, 3'd2, $urandom, 0, 0, 32'h0));
        for (int i = 0; i < 300; i++) begin
            int t;
            r.sel = ($urandom_range(0, 9) != 0);
            t = $urandom_range(0, 9);
            r.trans = (t < 1) ? 2'b00 : (t < 2) ? 2'b01 : (t < 6) ? 2'b10 : 2'b11;
            r.size  = ($urandom_range(0, 19) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            r.addr  = 32'($urandom_range(0, DEPTH * 4 - 1));
            if ($urandom_range(0, 9) == 0) r.addr = r.addr | (32'h1 << $urandom_range(AW + 2, 31));
            r.wr = 1'($urandom_range(0, 1));
            r.wdata = $urandom;
            r.has_exp = 1'b0; r.exp_err = 1'b0; r.exp_rdata = 32'h0;
            q.push_back(r);
        end
        run_queue();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
